ddk_data_rd_port: RTL and testbench

//  FPGA->MCU readback path on the 16-bit parallel DATA bus, opposite direction to the DataClk/DataWe write path.

---
 rtl/ddk_pkg.sv | 22 ++
 rtl/ddk_sync_fifo.sv | 76 +++++++
 rtl/ddk_data_rd_port.sv | 187 ++++++++++++++++++
 tb/tb_ddk_data_rd_port.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddk_pkg.sv
// ----------------------------------------------------------------------------
// ddk_pkg
// Shared constants for the DDK data-bus blocks.
//   DDK_DATA_W : width of the parallel DATA bus.
//   RD_*       : encoding of the read-port output FSM.
//   rd_state_e : typed view of that encoding, used by ddk_data_rd_port.
// ----------------------------------------------------------------------------
package ddk_pkg;

  localparam int DDK_DATA_W = 16;

  localparam logic [1:0] RD_EMPTY = 2'd0;
  localparam logic [1:0] RD_LOAD  = 2'd1;
  localparam logic [1:0] RD_VALID = 2'd2;

  typedef enum logic [1:0] {
    RD_ST_EMPTY = RD_EMPTY,
    RD_ST_LOAD  = RD_LOAD,
    RD_ST_VALID = RD_VALID
  } rd_state_e;

endpackage

// File: rtl/ddk_sync_fifo.sv
// ----------------------------------------------------------------------------
// ddk_sync_fifo
// Single-clock FIFO with registered read/write pointers. Each pointer carries
// one extra MSB so full and empty can be told apart when the index bits match.
// The head word is available combinationally on rdata_o.
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset (clears pointers only)
//   push_i   : write wdata_i this cycle (ignored when full)
//   wdata_i  : data to write
//   pop_i    : drop the head word this cycle (ignored when empty)
//   rdata_o  : current head word
//   full_o   : DEPTH words stored
//   empty_o  : no words stored
//   level_o  : number of words stored
// ----------------------------------------------------------------------------
module ddk_sync_fifo
  import ddk_pkg::*;
#(
  parameter int DATA_W = DDK_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers already marks
  // every entry invalid, and a reset here would stop RAM inference.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ddk_data_rd_port.sv
// ----------------------------------------------------------------------------
// ddk_data_rd_port
// FPGA->MCU readback path on the 16-bit parallel DATA bus. Words from
// ddk_core are buffered in a FIFO; the head word is moved into an output
// register and presented on DataOut. A rising edge on the MCU-driven DataClk
// (while DataRe is high) acknowledges the presented word and advances to the
// next one. DataClk and DataRe are asynchronous and pass through
// SYNC_STAGES flops before use.
// Ports:
//   SysClk        : system clock (only clock)
//   SysRst        : synchronous active-low reset
//   WrData/WrValid/WrReady : producer handshake from ddk_core
//   DataClk       : MCU strobe, rising edge = presented word consumed
//   DataRe        : MCU read enable, high = FPGA drives the bus
//   DataOut       : presented word (BIBUF D)
//   DataOe        : bus output enable (BIBUF E) = synchronized DataRe
//   DataRdy       : DataOut holds a valid unread word
//   Level         : FIFO occupancy, not counting the presented word
// Optional (macro DDK_RD_STATS_EN):
//   UnderflowCnt  : saturating count of acknowledges seen with no valid word
//   OverrunSticky : set once the producer offered a word while WrReady was 0
// ----------------------------------------------------------------------------
module ddk_data_rd_port
  import ddk_pkg::*;
#(
  parameter int DATA_W      = DDK_DATA_W,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     SysClk,
  input  logic                     SysRst,
  input  logic [DATA_W-1:0]        WrData,
  input  logic                     WrValid,
  output logic                     WrReady,
  input  logic                     DataClk,
  input  logic                     DataRe,
  output logic [DATA_W-1:0]        DataOut,
  output logic                     DataOe,
  output logic                     DataRdy,
  output logic [$clog2(DEPTH):0]   Level
`ifdef DDK_RD_STATS_EN
  ,
  output logic [7:0]               UnderflowCnt,
  output logic                     OverrunSticky
`endif
);

  // --------------------------------------------------------------------------
  // Synchronizers. Bit SYNC_STAGES-1 is the synchronized level; one extra
  // flop on the strobe turns its rising edge into a single-cycle pulse.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] re_sync_q;
  logic                   clk_sync_dly_q;
  logic                   clk_rise;
  logic                   data_oe;

  always_ff @(posedge SysClk) begin
    if (!SysRst) begin
      clk_sync_q     <= '0;
      re_sync_q      <= '0;
      clk_sync_dly_q <= 1'b0;
    end else begin
      clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], DataClk};
      re_sync_q      <= {re_sync_q[SYNC_STAGES-2:0], DataRe};
      clk_sync_dly_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_dly_q;
  assign data_oe  = re_sync_q[SYNC_STAGES-1];
  assign DataOe   = data_oe;

  // --------------------------------------------------------------------------
  // FIFO. WrReady is forced low while reset is asserted so the producer never
  // sees a handshake that reset is about to discard.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_push;

  assign WrReady   = SysRst & ~fifo_full;
  assign fifo_push = WrValid & WrReady;

  ddk_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (SysClk),
    .rst_ni  (SysRst),
    .push_i  (fifo_push),
    .wdata_i (WrData),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (Level)
  );

  // --------------------------------------------------------------------------
  // Output FSM. LOAD is a one-cycle settle state between the first word
  // landing in the output register and DataRdy rising, so the bus value is
  // stable before the MCU is told it is valid.
  // --------------------------------------------------------------------------
  rd_state_e         state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rdy_q, rdy_d;

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    rdy_d    = rdy_q;
    fifo_pop = 1'b0;
    case (state_q)
      RD_ST_EMPTY: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dout_d   = fifo_rdata;
          state_d  = RD_ST_LOAD;
        end
      end
      RD_ST_LOAD: begin
        rdy_d   = 1'b1;
        state_d = RD_ST_VALID;
      end
      RD_ST_VALID: begin
        // An acknowledge with the bus disabled is not a real read.
        if (clk_rise && data_oe) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            dout_d   = fifo_rdata;
          end else begin
            rdy_d   = 1'b0;
            state_d = RD_ST_EMPTY;
          end
        end
      end
      default: begin
        rdy_d   = 1'b0;
        state_d = RD_ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (!SysRst) begin
      state_q <= RD_ST_EMPTY;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
    end
  end

  assign DataOut = dout_q;
  assign DataRdy = rdy_q;

`ifdef DDK_RD_STATS_EN
  // --------------------------------------------------------------------------
  // Debug statistics, cleared only by reset.
  // --------------------------------------------------------------------------
  logic [7:0] underflow_cnt_q;
  logic       overrun_q;

  always_ff @(posedge SysClk) begin
    if (!SysRst) begin
      underflow_cnt_q <= 8'd0;
      overrun_q       <= 1'b0;
    end else begin
      if (clk_rise && data_oe && !rdy_q && (underflow_cnt_q != 8'hFF))
        underflow_cnt_q <= underflow_cnt_q + 8'd1;
      if (WrValid && !WrReady)
        overrun_q <= 1'b1;
    end
  end

  assign UnderflowCnt  = underflow_cnt_q;
  assign OverrunSticky = overrun_q;
`endif

endmodule

// File: tb/tb_ddk_data_rd_port.sv
// ----------------------------------------------------------------------------
// tb_ddk_data_rd_port
// Self-checking bench for ddk_data_rd_port. A queue-based model tracks the
// FIFO contents, the presented word and the synchronizer delay line; a
// compare process checks every DUT output against it on each falling edge.
// Directed scenarios add literal expectations, then a randomized phase runs
// producer traffic, MCU strobes and read-enable changes against the model.
// ----------------------------------------------------------------------------
module tb_ddk_data_rd_port;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int SYNC   = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              SysClk = 1'b0;
  logic              SysRst = 1'b0;
  logic [DATA_W-1:0] WrData = '0;
  logic              WrValid = 1'b0;
  logic              WrReady;
  logic              DataClk = 1'b0;
  logic              DataRe = 1'b0;
  logic [DATA_W-1:0] DataOut;
  logic              DataOe;
  logic              DataRdy;
  logic [LW-1:0]     Level;
`ifdef DDK_RD_STATS_EN
  logic [7:0]        UnderflowCnt;
  logic              OverrunSticky;
`endif

  always #5 SysClk = ~SysClk;

  ddk_data_rd_port #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .SysClk  (SysClk),
    .SysRst  (SysRst),
    .WrData  (WrData),
    .WrValid (WrValid),
    .WrReady (WrReady),
    .DataClk (DataClk),
    .DataRe  (DataRe),
    .DataOut (DataOut),
    .DataOe  (DataOe),
    .DataRdy (DataRdy),
    .Level   (Level)
`ifdef DDK_RD_STATS_EN
    ,
    .UnderflowCnt  (UnderflowCnt),
    .OverrunSticky (OverrunSticky)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Words waiting in the FIFO live in a queue; the presented
  // word is a separate slot that becomes visible one cycle after it is taken.
  // The synchronizers are modelled as a plain delay line of pin samples.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_out = '0;
  bit                m_rdy = 1'b0;
  bit                m_load = 1'b0;
  logic [SYNC:0]     m_clk_h = '0;
  logic [SYNC:0]     m_re_h = '0;
  bit                cmp_en = 1'b0;
  int                m_uf = 0;
  bit                m_ovr = 1'b0;

  always @(posedge SysClk) begin : model
    bit rise, oe, push;
    if (!SysRst) begin
      mq.delete();
      m_out   = '0;
      m_rdy   = 1'b0;
      m_load  = 1'b0;
      m_clk_h = '0;
      m_re_h  = '0;
      m_uf    = 0;
      m_ovr   = 1'b0;
      cmp_en  = 1'b1;
    end else begin
      rise = m_clk_h[SYNC-1] && !m_clk_h[SYNC];
      oe   = m_re_h[SYNC-1];
      push = WrValid && (mq.size() < DEPTH);
      if (rise && oe && !m_rdy && m_uf < 255) m_uf++;
      if (WrValid && !push) m_ovr = 1'b1;
      if (m_load) begin
        m_load = 1'b0;
        m_rdy  = 1'b1;
      end else if (!m_rdy) begin
        if (mq.size() != 0) begin
          m_out  = mq.pop_front();
          m_load = 1'b1;
        end
      end else if (rise && oe) begin
        if (mq.size() != 0) m_out = mq.pop_front();
        else                m_rdy = 1'b0;
      end
      if (push) mq.push_back(WrData);
      m_clk_h = {m_clk_h[SYNC-1:0], DataClk};
      m_re_h  = {m_re_h[SYNC-1:0], DataRe};
    end
  end

  always @(negedge SysClk) begin : compare
    if (cmp_en) begin
      check("m_DataOut", 32'(DataOut), 32'(m_out));
      check("m_DataRdy", 32'(DataRdy), 32'(m_rdy));
      check("m_DataOe",  32'(DataOe),  32'(m_re_h[SYNC-1]));
      check("m_Level",   32'(Level),   32'(mq.size()));
      check("m_WrReady", 32'(WrReady), 32'(SysRst && (mq.size() < DEPTH)));
`ifdef DDK_RD_STATS_EN
      check("m_UnderflowCnt",  32'(UnderflowCnt),  32'(m_uf));
      check("m_OverrunSticky", 32'(OverrunSticky), 32'(m_ovr));
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge SysClk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    DataClk = 1'b1;
    ticks(SYNC + 3);
    DataClk = 1'b0;
    ticks(SYNC + 3);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    bit acc;
    bit done;
    done    = 1'b0;
    WrData  = w;
    WrValid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      acc = WrReady;
      tick();
      if (acc) done = 1'b1;
    end
    WrValid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout: word %0h not accepted within 200 cycles", w);
    end
  endtask

  initial begin
    // Reset held with the producer offering a word.
    SysRst  = 1'b0;
    WrValid = 1'b1;
    WrData  = 16'hDEAD;
    ticks(5);
    check("rst_DataOut", 32'(DataOut), 32'h0);
    check("rst_DataRdy", 32'(DataRdy), 32'h0);
    check("rst_DataOe",  32'(DataOe),  32'h0);
    check("rst_Level",   32'(Level),   32'h0);
    check("rst_WrReady", 32'(WrReady), 32'h0);
    WrValid = 1'b0;
    SysRst  = 1'b1;
    tick();
    check("rel_WrReady", 32'(WrReady), 32'h1);

    // Single word: DataRdy rises three edges after the word is offered.
    DataRe = 1'b1;
    ticks(SYNC + 1);
    WrData  = 16'hA55A;
    WrValid = 1'b1;
    tick();
    WrValid = 1'b0;
    tick();
    check("single_rdy_early", 32'(DataRdy), 32'h0);
    tick();
    check("single_rdy",  32'(DataRdy), 32'h1);
    check("single_dout", 32'(DataOut), 32'hA55A);
    check("single_oe",   32'(DataOe),  32'h1);
    pulse();
    check("single_ack_rdy", 32'(DataRdy), 32'h0);

    // Burst: 17 words fill FIFO plus the presented slot.
    for (int w = 1; w <= 17; w++) push_word(16'(w));
    ticks(2);
    check("burst_level",   32'(Level),   32'd16);
    check("burst_wrready", 32'(WrReady), 32'h0);
    check("burst_first",   32'(DataOut), 32'h1);
    for (int w = 1; w <= 17; w++) begin
      check("burst_word", 32'(DataOut), 32'(w));
      pulse();
    end
    check("burst_drained_rdy", 32'(DataRdy), 32'h0);

    // Simultaneous push and pop at Level 8.
    for (int i = 0; i < 9; i++) push_word(16'h0101 + 16'(i));
    ticks(3);
    check("pp_level_before", 32'(Level), 32'd8);
    DataClk = 1'b1;
    ticks(SYNC);
    WrData  = 16'h0200;
    WrValid = 1'b1;
    tick();
    WrValid = 1'b0;
    check("pp_level_after", 32'(Level),   32'd8);
    check("pp_dout",        32'(DataOut), 32'h0102);
    ticks(SYNC + 2);
    DataClk = 1'b0;
    ticks(SYNC + 3);
    for (int i = 1; i < 10; i++) begin
      check("pp_word", 32'(DataOut), (i < 9) ? 32'(16'h0101 + 16'(i)) : 32'h0200);
      pulse();
    end
    check("pp_drained_rdy", 32'(DataRdy), 32'h0);

    // Underflow: strobe with nothing to present.
    pulse();
    check("uf_dout", 32'(DataOut), 32'h0200);
    check("uf_rdy",  32'(DataRdy), 32'h0);
`ifdef DDK_RD_STATS_EN
    check("uf_cnt1", 32'(UnderflowCnt), 32'd1);
    for (int i = 0; i < 299; i++) pulse();
    check("uf_sat", 32'(UnderflowCnt), 32'hFF);
`endif

    // Reset in the middle of a read sequence.
    for (int i = 0; i < 5; i++) push_word(16'h0500 + 16'(i));
    ticks(3);
    check("mid_w0", 32'(DataOut), 32'h0500);
    pulse();
    check("mid_w1", 32'(DataOut), 32'h0501);
    pulse();
    SysRst = 1'b0;
    ticks(2);
    check("mid_rst_level", 32'(Level),   32'h0);
    check("mid_rst_rdy",   32'(DataRdy), 32'h0);
    SysRst = 1'b1;
    ticks(SYNC + 2);
    push_word(16'h1234);
    ticks(3);
    check("mid_new_rdy",  32'(DataRdy), 32'h1);
    check("mid_new_dout", 32'(DataOut), 32'h1234);

    // Randomized traffic against the model.
    begin
      bit acc;
      int hold;
      int wr_pct;
      acc  = 1'b0;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
        wr_pct = ((c / 500) % 2 == 0) ? 70 : 3;
        if (!WrValid || acc) begin
          WrValid = ($urandom_range(0, 99) < wr_pct);
          WrData  = 16'($urandom);
        end
        if (hold > 0) hold--;
        else if ($urandom_range(0, 3) == 0) begin
          DataClk = ~DataClk;
          hold    = SYNC + 3 + int'($urandom_range(0, 4));
        end
        if ($urandom_range(0, 199) == 0) DataRe = ~DataRe;
        acc = WrValid && WrReady;
        tick();
      end
      WrValid = 1'b0;
      ticks(SYNC + 4);
      DataClk = 1'b0;
      ticks(SYNC + 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
